// File: rtl/cnt5_down_seq.sv
// -----------------------------------------------------------------------------
// cnt5_down_seq
//
// Loadable down-counter sequencer. It bounds the kernel and row loops of the
// sharpening datapath and gives the DLX control logic an end-of-loop handshake.
// A LOAD starts a count from LD_VAL. Each CE while running removes one
// iteration. When the last iteration is consumed, TC pulses for one cycle and
// DONE is held until the controller acknowledges it or starts a new count.
//
// Ports
//   CLK     in   1      rising-edge clock
//   RST     in   1      asynchronous, active-high reset
//   LOAD    in   1      load LD_VAL and start a count
//   LD_VAL  in   WIDTH  start value (iteration count)
//   CE      in   1      count enable, one decrement per cycle while running
//   ACK     in   1      acknowledge DONE and return to idle
//   CNT     out  WIDTH  current count (registered)
//   BUSY    out  1      high while counting
//   TC      out  1      terminal-count pulse, one cycle wide
//   DONE    out  1      high from terminal count until ACK or LOAD
// -----------------------------------------------------------------------------
module cnt5_down_seq #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic             CE,
    input  logic             ACK,
    output logic [WIDTH-1:0] CNT,
    output logic             BUSY,
    output logic             TC,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;
    logic             busy_q;
    logic             done_q;

    // State, count and all flag outputs are registered together, so every
    // output changes only on a clock edge (or on reset) and there is no
    // combinational path from any input to any output. BUSY and DONE are
    // decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Next-state and next-count logic. LOAD has priority over everything else
    // in every state. A zero load means there is nothing to iterate, so the
    // count finishes immediately and raises TC. Otherwise the counter runs.
    // While running, the decrement from 1 is the terminal step. The counter
    // goes to 0 and leaves RUN on that edge, so it never goes below zero.
    // The "<= 1" test also covers a zero count in RUN, which cannot happen.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;

        if (LOAD) begin
            if (LD_VAL == CNT_ZERO) begin
                state_d = S_DONE;
                cnt_d   = CNT_ZERO;
                tc_d    = 1'b1;
            end else begin
                state_d = S_RUN;
                cnt_d   = LD_VAL;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_RUN: begin
                    if (CE) begin
                        if (cnt_q > CNT_ONE) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end else begin
                            cnt_d   = CNT_ZERO;
                            tc_d    = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    cnt_d = CNT_ZERO;
                    if (ACK) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    assign CNT  = cnt_q;
    assign BUSY = busy_q;
    assign TC   = tc_q;
    assign DONE = done_q;

endmodule
